// File: rtl/data_mem_rmw_pkg.sv
// Shared encodings and lane helpers for the data-memory stage.
package data_mem_rmw_pkg;

  localparam logic [1:0] MEM_ACC_NONE = 2'd0;
  localparam logic [1:0] MEM_ACC_BYTE = 2'd1;
  localparam logic [1:0] MEM_ACC_HALF = 2'd2;
  localparam logic [1:0] MEM_ACC_WORD = 2'd3;

  localparam logic [31:0] MEM_DATA_BASE = 32'h0001_0000;

  typedef enum logic [1:0] {
    DMEM_ST_IDLE   = 2'd0,
    DMEM_ST_RMW_RD = 2'd1,
    DMEM_ST_RMW_WR = 2'd2
  } dmem_state_e;

  function automatic logic is_misaligned(input logic [1:0] acc, input logic [1:0] lane);
    return ((acc == MEM_ACC_HALF) && lane[0]) || ((acc == MEM_ACC_WORD) && (lane != 2'b00));
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [15:0] data,
                                             input logic [1:0] lane, input logic [1:0] acc);
    logic [31:0] r;
    r = word;
    if (acc == MEM_ACC_BYTE) begin
      r[{lane, 3'b000} +: 8] = data[7:0];
    end else if (lane[1]) begin
      r[31:16] = data;
    end else begin
      r[15:0] = data;
    end
    return r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] acc, input logic sext);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (acc)
      MEM_ACC_BYTE: return {{24{sext & b[7]}}, b};
      MEM_ACC_HALF: return {{16{sext & h[15]}}, h};
      default:      return word;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_rmw_ram_sp.sv
// Single-port 32-bit RAM, registered read.
module data_mem_rmw_ram_sp #(
  parameter int ADDR_W    = 10,
  parameter     INIT_FILE = ""
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [0:(1<<ADDR_W)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_rmw.sv
// Data-memory stage: byte/half/word loads and stores, sub-word stores via read-modify-write.
module data_mem_rmw
  import data_mem_rmw_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] MEM_BASE  = MEM_DATA_BASE,
  parameter              INIT_FILE = ""
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        sext_i,
  input  logic [1:0]  acc_r_i,
  input  logic [31:0] addr_r_i,
  output logic [31:0] data_r_o,
  input  logic        wr_en_i,
  input  logic [1:0]  acc_w_i,
  input  logic [31:0] addr_w_i,
  input  logic [31:0] data_w_i,
  output logic        wr_ready_o,
  output logic        misalign_o
);

  dmem_state_e       state_q;
  logic [ADDR_W-1:0] st_idx_q;
  logic [1:0]        st_lane_q;
  logic [1:0]        st_acc_q;
  logic [15:0]       st_data_q;
  logic [31:0]       merged_q;
  logic              load_pend_q;
  logic              load_err_q;
  logic [1:0]        load_acc_q;
  logic [1:0]        load_lane_q;
  logic              load_sext_q;
  logic [31:0]       data_r_q;
  logic              misalign_q;

  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;

  logic is_idle, w_valid, w_bad, r_bad, r_req, st_start;

  // Base is aligned to the RAM size, so range is a compare of the upper address bits.
  assign is_idle  = (state_q == DMEM_ST_IDLE);
  assign w_valid  = (acc_w_i != MEM_ACC_NONE);
  assign w_bad    = w_valid && ((addr_w_i[31:ADDR_W+2] != MEM_BASE[31:ADDR_W+2]) ||
                                is_misaligned(acc_w_i, addr_w_i[1:0]));
  assign r_bad    = (addr_r_i[31:ADDR_W+2] != MEM_BASE[31:ADDR_W+2]) ||
                    is_misaligned(acc_r_i, addr_r_i[1:0]);
  assign r_req    = is_idle && !wr_en_i && (acc_r_i != MEM_ACC_NONE);
  assign st_start = is_idle && wr_en_i && w_valid && !w_bad && (acc_w_i != MEM_ACC_WORD);

  assign wr_ready_o = wr_en_i && ((is_idle && !st_start) || (state_q == DMEM_ST_RMW_WR));
  assign data_r_o   = data_r_q;
  assign misalign_o = misalign_q;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr_r_i[ADDR_W+1:2];
    ram_wdata = data_w_i;
    case (state_q)
      DMEM_ST_IDLE: begin
        if (wr_en_i) begin
          ram_addr = addr_w_i[ADDR_W+1:2];
          if (w_valid && !w_bad) begin
            ram_en = 1'b1;
            ram_we = (acc_w_i == MEM_ACC_WORD);
          end
        end else if (r_req && !r_bad) begin
          ram_en = 1'b1;
        end
      end
      DMEM_ST_RMW_WR: begin
        ram_en    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = st_idx_q;
        ram_wdata = merged_q;
      end
      default: ;
    endcase
  end

  data_mem_rmw_ram_sp #(
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk_i  (clk_i),
    .en_i   (ram_en),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= DMEM_ST_IDLE;
      st_idx_q    <= '0;
      st_lane_q   <= 2'b00;
      st_acc_q    <= MEM_ACC_NONE;
      st_data_q   <= 16'h0000;
      merged_q    <= 32'h0;
      load_pend_q <= 1'b0;
      load_err_q  <= 1'b0;
      load_acc_q  <= MEM_ACC_NONE;
      load_lane_q <= 2'b00;
      load_sext_q <= 1'b0;
      data_r_q    <= 32'h0;
      misalign_q  <= 1'b0;
    end else begin
      misalign_q  <= is_idle && ((wr_en_i && w_bad) || (r_req && r_bad));
      load_pend_q <= r_req;
      if (r_req) begin
        load_err_q  <= r_bad;
        load_acc_q  <= acc_r_i;
        load_lane_q <= addr_r_i[1:0];
        load_sext_q <= sext_i;
      end
      if (load_pend_q) begin
        data_r_q <= load_err_q ? 32'h0 : load_extend(ram_rdata, load_lane_q, load_acc_q, load_sext_q);
      end
      case (state_q)
        DMEM_ST_IDLE: begin
          if (st_start) begin
            st_idx_q  <= addr_w_i[ADDR_W+1:2];
            st_lane_q <= addr_w_i[1:0];
            st_acc_q  <= acc_w_i;
            st_data_q <= data_w_i[15:0];
            state_q   <= DMEM_ST_RMW_RD;
          end
        end
        DMEM_ST_RMW_RD: begin
          merged_q <= lane_merge(ram_rdata, st_data_q, st_lane_q, st_acc_q);
          state_q  <= DMEM_ST_RMW_WR;
        end
        default: state_q <= DMEM_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_rmw.sv
// Directed bench for data_mem_rmw: loads, word/sub-word stores, error and reset cases.
module tb_data_mem_rmw;
  import data_mem_rmw_pkg::*;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sext = 1'b0;
  logic [1:0]  acc_r = MEM_ACC_NONE;
  logic [31:0] addr_r = 32'h0;
  logic [31:0] data_r;
  logic        wr_en = 1'b0;
  logic [1:0]  acc_w = MEM_ACC_NONE;
  logic [31:0] addr_w = 32'h0;
  logic [31:0] data_w = 32'h0;
  logic        wr_ready;
  logic        misalign;

  int errors = 0;
  int checks = 0;
  int rdy_cnt = 0;

  always #5 clk = ~clk;

  data_mem_rmw #(.ADDR_W(10), .MEM_BASE(BASE), .INIT_FILE("")) dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .sext_i    (sext),
    .acc_r_i   (acc_r),
    .addr_r_i  (addr_r),
    .data_r_o  (data_r),
    .wr_en_i   (wr_en),
    .acc_w_i   (acc_w),
    .addr_w_i  (addr_w),
    .data_w_i  (data_w),
    .wr_ready_o(wr_ready),
    .misalign_o(misalign)
  );

  always @(negedge clk) begin
    #2;
    if (wr_ready) rdy_cnt = rdy_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Holds the request until wr_ready, then drops it just after the accepting edge.
  task automatic do_store(input logic [1:0] acc, input logic [31:0] addr, input logic [31:0] data,
                          output int stalls, output logic mis, output int pulses);
    int n;
    int base_cnt;
    n = 0;
    base_cnt = rdy_cnt;
    @(negedge clk);
    wr_en = 1'b1; acc_w = acc; addr_w = addr; data_w = data;
    #1;
    while (!wr_ready && n < 10) begin
      @(negedge clk);
      #1;
      n = n + 1;
    end
    if (n >= 10) check_eq("store_timeout", 32'(n), 32'd0);
    stalls = n;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    mis = misalign;
    #1;
    check_eq("ready_without_req", 32'(wr_ready), 32'd0);
    @(negedge clk);
    #3;
    pulses = rdy_cnt - base_cnt;
    $display("store acc=%0d addr=0x%08h data=0x%08h stalls=%0d misalign=%0b", acc, addr, data, stalls, mis);
  endtask

  task automatic do_load(input logic [1:0] acc, input logic s, input logic [31:0] addr,
                         output logic [31:0] d, output logic mis);
    @(negedge clk);
    acc_r = acc; sext = s; addr_r = addr;
    @(posedge clk);
    #1;
    acc_r = MEM_ACC_NONE;
    mis = misalign;
    @(posedge clk);
    #1;
    d = data_r;
    $display("load  acc=%0d sext=%0b addr=0x%08h data=0x%08h misalign=%0b", acc, s, addr, d, mis);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int st, pl;
    logic m;
    logic [31:0] d;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data_r", data_r, 32'h0);
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd0);
    check_eq("rst_misalign", 32'(misalign), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // 1: word store, zero-latency ready, then load back
    do_store(MEM_ACC_WORD, BASE, 32'h1122_3344, st, m, pl);
    check_eq("sw_stalls", 32'(st), 32'd0);
    check_eq("sw_misalign", 32'(m), 32'd0);
    do_load(MEM_ACC_WORD, 1'b0, BASE, d, m);
    check_eq("lw1", d, 32'h1122_3344);
    repeat (2) @(posedge clk);
    #1;
    check_eq("lw1_hold", data_r, 32'h1122_3344);

    // 2: byte store via RMW
    do_store(MEM_ACC_BYTE, BASE + 1, 32'h0000_00A5, st, m, pl);
    check_eq("sb_stalls", 32'(st), 32'd2);
    check_eq("sb_pulse", 32'(pl), 32'd1);
    do_load(MEM_ACC_WORD, 1'b0, BASE, d, m);
    check_eq("lw2", d, 32'h1122_A544);
    do_load(MEM_ACC_BYTE, 1'b1, BASE + 1, d, m);
    check_eq("lb2", d, 32'hFFFF_FFA5);
    do_load(MEM_ACC_BYTE, 1'b0, BASE + 1, d, m);
    check_eq("lbu2", d, 32'h0000_00A5);

    // 3: half store via RMW
    do_store(MEM_ACC_HALF, BASE + 2, 32'h0000_8001, st, m, pl);
    check_eq("sh_stalls", 32'(st), 32'd2);
    do_load(MEM_ACC_WORD, 1'b0, BASE, d, m);
    check_eq("lw3", d, 32'h8001_A544);
    do_load(MEM_ACC_HALF, 1'b1, BASE + 2, d, m);
    check_eq("lh3", d, 32'hFFFF_8001);
    do_load(MEM_ACC_HALF, 1'b0, BASE + 2, d, m);
    check_eq("lhu3", d, 32'h0000_8001);
    do_store(MEM_ACC_BYTE, BASE + 8, 32'h0000_0099, st, m, pl);
    check_eq("load_hold_over_store", data_r, 32'h0000_8001);

    // 4: misaligned load and store
    do_load(MEM_ACC_WORD, 1'b0, BASE + 2, d, m);
    check_eq("lw_mis_flag", 32'(m), 32'd1);
    check_eq("lw_mis_data", d, 32'h0);
    check_eq("mis_one_cycle", 32'(misalign), 32'd0);
    do_store(MEM_ACC_HALF, BASE + 1, 32'h0000_BEEF, st, m, pl);
    check_eq("sh_mis_stalls", 32'(st), 32'd0);
    check_eq("sh_mis_flag", 32'(m), 32'd1);
    do_load(MEM_ACC_WORD, 1'b0, BASE, d, m);
    check_eq("lw4_unchanged", d, 32'h8001_A544);
    check_eq("lw4_no_mis", 32'(m), 32'd0);

    // 5: out-of-range accesses (the store would alias word 0)
    do_store(MEM_ACC_BYTE, BASE + 32'h1000, 32'h0000_00EE, st, m, pl);
    check_eq("sb_oor_stalls", 32'(st), 32'd0);
    check_eq("sb_oor_flag", 32'(m), 32'd1);
    do_load(MEM_ACC_WORD, 1'b0, BASE - 4, d, m);
    check_eq("lw_oor_flag", 32'(m), 32'd1);
    check_eq("lw_oor_data", d, 32'h0);
    do_load(MEM_ACC_WORD, 1'b0, BASE, d, m);
    check_eq("lw5_unchanged", d, 32'h8001_A544);

    // 5b: reset while in RMW_RD
    @(negedge clk);
    wr_en = 1'b1; acc_w = MEM_ACC_BYTE; addr_w = BASE; data_w = 32'h0000_0077;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_eq("rmw_rst_fsm", 32'(dut.state_q), 32'(DMEM_ST_IDLE));
    check_eq("rmw_rst_ready", 32'(wr_ready), 32'd0);
    check_eq("rmw_rst_data_r", data_r, 32'h0);
    check_eq("rmw_rst_misalign", 32'(misalign), 32'd0);
    wr_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    do_load(MEM_ACC_WORD, 1'b0, BASE, d, m);
    check_eq("lw_after_rst", d, 32'h8001_A544);

    // 6: back-to-back byte stores into one word
    for (int i = 0; i < 4; i++) begin
      logic [31:0] bv;
      bv = 32'h11 * (i + 1);
      do_store(MEM_ACC_BYTE, BASE + 32'h10 + i, bv, st, m, pl);
      check_eq($sformatf("b2b_stalls%0d", i), 32'(st), 32'd2);
      check_eq($sformatf("b2b_pulse%0d", i), 32'(pl), 32'd1);
    end
    do_load(MEM_ACC_WORD, 1'b0, BASE + 32'h10, d, m);
    check_eq("lw6", d, 32'h4433_2211);
    do_load(MEM_ACC_BYTE, 1'b1, BASE + 32'h13, d, m);
    check_eq("lb6_pos", d, 32'h0000_0044);
    do_load(MEM_ACC_HALF, 1'b1, BASE + 32'h12, d, m);
    check_eq("lh6_pos", d, 32'h0000_4433);

    // store with NONE size is a consumed no-op
    do_store(MEM_ACC_NONE, BASE + 32'h10, 32'hDEAD_BEEF, st, m, pl);
    check_eq("none_stalls", 32'(st), 32'd0);
    check_eq("none_misalign", 32'(m), 32'd0);
    do_load(MEM_ACC_WORD, 1'b0, BASE + 32'h10, d, m);
    check_eq("lw_after_none", d, 32'h4433_2211);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
